// File: rtl/led_status_pkg.sv
// Shared state encodings and constants for the multi-LED battery/fan status indicator.
package led_status_pkg;

   localparam int unsigned STATE_W   = 3;
   localparam int unsigned BATT_FULL = 100;

   localparam logic [STATE_W-1:0] S_OFF    = 3'd0;
   localparam logic [STATE_W-1:0] S_DISCHG = 3'd1;
   localparam logic [STATE_W-1:0] S_LOW    = 3'd2;
   localparam logic [STATE_W-1:0] S_CHG    = 3'd3;
   localparam logic [STATE_W-1:0] S_FULL   = 3'd4;

   // Battery percentage above which bar-graph LED idx is lit.
   function automatic int unsigned led_threshold(input int unsigned idx, input int unsigned num_led);
      return (idx * BATT_FULL) / num_led;
   endfunction

endpackage

// File: rtl/led_breathe_gen.sv
// Breathing PWM generator: triangle-ramped duty, one duty step every STEP_DIV PWM periods.
module led_breathe_gen #(
   parameter int unsigned PWM_W    = 8,
   parameter int unsigned STEP_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   output logic             breathe,
   output logic [PWM_W-1:0] duty
);

   localparam int unsigned      STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [PWM_W-1:0]  PWM_MAX   = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0]  PWM_ONE   = PWM_W'(1);

   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [PWM_W-1:0]  duty_q, duty_d;
   logic              dir_up_q, dir_up_d;
   logic              breathe_q, breathe_d;

   // Ramp turns around on reaching either end, so duty never overshoots or wraps.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
      step_cnt_d = step_cnt_q;
      duty_d     = duty_q;
      dir_up_d   = dir_up_q;
      if (restart) begin
         pwm_cnt_d  = '0;
         step_cnt_d = '0;
         duty_d     = '0;
         dir_up_d   = 1'b1;
      end else if (pwm_cnt_q == PWM_MAX) begin
         if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (dir_up_q) begin
               if (duty_q == PWM_MAX) begin
                  duty_d   = duty_q - PWM_ONE;
                  dir_up_d = 1'b0;
               end else begin
                  duty_d = duty_q + PWM_ONE;
                  if (duty_q == PWM_MAX - PWM_ONE) dir_up_d = 1'b0;
               end
            end else begin
               if (duty_q == '0) begin
                  duty_d   = duty_q + PWM_ONE;
                  dir_up_d = 1'b1;
               end else begin
                  duty_d = duty_q - PWM_ONE;
                  if (duty_q == PWM_ONE) dir_up_d = 1'b1;
               end
            end
         end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
         end
      end
      breathe_d = (pwm_cnt_d < duty_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q  <= '0;
         step_cnt_q <= '0;
         duty_q     <= '0;
         dir_up_q   <= 1'b1;
         breathe_q  <= 1'b0;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         step_cnt_q <= step_cnt_d;
         duty_q     <= duty_d;
         dir_up_q   <= dir_up_d;
         breathe_q  <= breathe_d;
      end
   end

   assign breathe = breathe_q;
   assign duty    = duty_q;

endmodule

// File: rtl/led_status_multi.sv
// Multi-LED battery bar graph with breathing charge LED, blinking low-battery
// warning with hysteresis, and fan-off blanking.
module led_status_multi
   import led_status_pkg::*;
#(
   parameter int unsigned NUM_LED    = 4,
   parameter int unsigned BATT_W     = 8,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned STEP_DIV   = 4,
   parameter int unsigned BLINK_HALF = 50,
   parameter int unsigned LOW_BATT   = 20,
   parameter int unsigned LOW_HYST   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [BATT_W-1:0]  battery,
   input  logic               charging,
   input  logic               fan_state,
   output logic [NUM_LED-1:0] led,
   output logic [2:0]         state_o,
   output logic [PWM_W-1:0]   duty_o
);

   localparam int unsigned        LIT_W      = $clog2(NUM_LED + 1);
   localparam int unsigned        BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   logic [BATT_W-1:0]  battery_q;
   logic               charging_q, fan_q;
   logic [STATE_W-1:0] state_q, state_d;
   logic [LIT_W-1:0]   lit_q, lit_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_ph_q, blink_ph_d;
   logic [NUM_LED-1:0] led_q, led_d;

   logic [BATT_W-1:0]  bc_c;
   logic               chg_entry_c, low_entry_c, breathe_c;
   logic [NUM_LED-1:0] lit_mask_c, chg_bit_c;

   // Clamped battery level and bar-graph count against fixed thresholds.
   always_comb begin
      bc_c = battery_q;
      if (32'(battery_q) > BATT_FULL) bc_c = BATT_W'(BATT_FULL);
      lit_d = '0;
      for (int unsigned i = 0; i < NUM_LED; i++) begin
         if (32'(bc_c) > led_threshold(i, NUM_LED)) lit_d = lit_d + LIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_OFF;
      else     state_q <= state_d;
   end

   // Next state; S_LOW is sticky until the battery clears the hysteresis band.
   always_comb begin
      state_d = state_q;
      if (!fan_q) begin
         state_d = S_OFF;
      end else if (charging_q && (bc_c == BATT_W'(BATT_FULL))) begin
         state_d = S_FULL;
      end else if (charging_q) begin
         state_d = S_CHG;
      end else if (state_q == S_LOW) begin
         if (32'(bc_c) >= LOW_BATT + LOW_HYST) state_d = S_DISCHG;
      end else if (32'(bc_c) <= LOW_BATT) begin
         state_d = S_LOW;
      end else begin
         state_d = S_DISCHG;
      end
      chg_entry_c = (state_d == S_CHG) && (state_q != S_CHG);
      low_entry_c = (state_d == S_LOW) && (state_q != S_LOW);
   end

   // LED map and blink timer; a breathing slot past the last LED simply drops out.
   always_comb begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      blink_ph_d  = blink_ph_q;
      if (low_entry_c) begin
         blink_cnt_d = '0;
         blink_ph_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end

      lit_mask_c = ~({NUM_LED{1'b1}} << lit_q);
      chg_bit_c  = NUM_LED'(breathe_c) << lit_q;
      led_d      = '0;
      case (state_q)
         S_DISCHG: led_d = lit_mask_c;
         S_LOW:    led_d = NUM_LED'(blink_ph_q);
         S_CHG:    led_d = lit_mask_c | chg_bit_c;
         S_FULL:   led_d = {NUM_LED{1'b1}};
         default:  led_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         battery_q   <= '0;
         charging_q  <= 1'b0;
         fan_q       <= 1'b0;
         lit_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
         led_q       <= '0;
      end else begin
         battery_q   <= battery;
         charging_q  <= charging;
         fan_q       <= fan_state;
         lit_q       <= lit_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         led_q       <= led_d;
      end
   end

   led_breathe_gen #(
      .PWM_W    (PWM_W),
      .STEP_DIV (STEP_DIV)
   ) u_breathe (
      .clk     (clk),
      .rst     (rst),
      .restart (chg_entry_c),
      .breathe (breathe_c),
      .duty    (duty_o)
   );

   assign led     = led_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_led_status_multi.sv
// Scoreboard bench for led_status_multi: 4-LED and 8-LED instances share stimulus,
// expectations come from a time-since-restart reference model.
module tb_led_status_multi;
   import led_status_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] battery;
   logic       charging, fan_state;
   logic [3:0] led4, duty4, duty8;
   logic [7:0] led8;
   logic [2:0] st4, st8;

   always #5 clk = ~clk;

   led_status_multi #(.NUM_LED(4), .BATT_W(8), .PWM_W(4), .STEP_DIV(2), .BLINK_HALF(3),
                      .LOW_BATT(20), .LOW_HYST(5)) u_dut4 (
      .clk(clk), .rst(rst), .battery(battery), .charging(charging), .fan_state(fan_state),
      .led(led4), .state_o(st4), .duty_o(duty4));

   led_status_multi #(.NUM_LED(8), .BATT_W(8), .PWM_W(4), .STEP_DIV(2), .BLINK_HALF(3),
                      .LOW_BATT(20), .LOW_HYST(5)) u_dut8 (
      .clk(clk), .rst(rst), .battery(battery), .charging(charging), .fan_state(fan_state),
      .led(led8), .state_o(st8), .duty_o(duty8));

   typedef struct {
      logic [2:0] st;
      logic [3:0] duty;
      logic [3:0] led4;
      logic [7:0] led8;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: registered inputs, state, bar count, LEDs, and time since ramp/blink origin.
   int         m_batt;
   bit         m_chg, m_fan;
   logic [2:0] m_state;
   int         m_lit4, m_lit8;
   logic [7:0] m_led4, m_led8;
   int         t_br, t_bl;

   // Duty after t clocks: one step per 16*2 clocks, triangle 0..15..0 with period 30 steps.
   function automatic int f_duty(input int t);
      int k;
      k = (t / 32) % 30;
      return (k <= 15) ? k : 30 - k;
   endfunction

   function automatic bit f_breathe(input int t);
      return (t % 16) < f_duty(t);
   endfunction

   function automatic bit f_phase(input int t);
      return ((t / 3) % 2) == 0;
   endfunction

   function automatic int f_lit(input int bc, input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) if (bc > (i * 100) / n) c++;
      return c;
   endfunction

   function automatic logic [2:0] f_next(input logic [2:0] cur, input int bc, input bit chg, input bit fan);
      if (!fan)              return S_OFF;
      if (chg && bc == 100)  return S_FULL;
      if (chg)               return S_CHG;
      if (cur == S_LOW)      return (bc >= 25) ? S_DISCHG : S_LOW;
      if (bc <= 20)          return S_LOW;
      return S_DISCHG;
   endfunction

   function automatic logic [7:0] f_led(input logic [2:0] st, input int lit, input int n,
                                        input bit br, input bit ph);
      logic [7:0] v;
      v = '0;
      if (st == S_DISCHG) begin
         for (int i = 0; i < lit; i++) v[i] = 1'b1;
      end else if (st == S_LOW) begin
         v[0] = ph;
      end else if (st == S_CHG) begin
         for (int i = 0; i < n; i++) begin
            if (i < lit)       v[i] = 1'b1;
            else if (i == lit) v[i] = br;
         end
      end else if (st == S_FULL) begin
         for (int i = 0; i < n; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic model_step(input bit r, input int b, input bit c, input bit f);
      exp_t       e;
      int         bc;
      logic [2:0] ns;
      if (r) begin
         m_batt = 0; m_chg = 0; m_fan = 0; m_state = S_OFF;
         m_lit4 = 0; m_lit8 = 0; m_led4 = '0; m_led8 = '0;
         t_br = 0; t_bl = 0;
      end else begin
         bc     = (m_batt > 100) ? 100 : m_batt;
         m_led4 = f_led(m_state, m_lit4, 4, f_breathe(t_br), f_phase(t_bl));
         m_led8 = f_led(m_state, m_lit8, 8, f_breathe(t_br), f_phase(t_bl));
         ns     = f_next(m_state, bc, m_chg, m_fan);
         t_br   = (ns == S_CHG && m_state != S_CHG) ? 0 : t_br + 1;
         t_bl   = (ns == S_LOW && m_state != S_LOW) ? 0 : t_bl + 1;
         m_lit4 = f_lit(bc, 4);
         m_lit8 = f_lit(bc, 8);
         m_state = ns;
         m_batt = b; m_chg = c; m_fan = f;
      end
      e.st   = m_state;
      e.duty = 4'(f_duty(t_br));
      e.led4 = m_led4[3:0];
      e.led8 = m_led8;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 want=1 at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("state4", 8'(st4), 8'(e.st));
            chk("state8", 8'(st8), 8'(e.st));
            chk("duty4", 8'(duty4), 8'(e.duty));
            chk("duty8", 8'(duty8), 8'(e.duty));
            chk("led4", 8'(led4), 8'(e.led4));
            chk("led8", led8, e.led8);
         end
      end
   end

   task automatic cyc(input bit r, input int b, input bit c, input bit f, input int n);
      repeat (n) begin
         rst       = r;
         battery   = 8'(b);
         charging  = c;
         fan_state = f;
         model_step(r, b, c, f);
         @(negedge clk);
      end
   endtask

   initial begin
      int b, sel, len;
      bit r, c, f;
      cyc(1, 0, 0, 0, 5);
      cyc(0, 50, 0, 1, 10);     // discharge bar graph
      cyc(0, 50, 1, 1, 1000);   // full breathing triangle
      cyc(0, 30, 0, 1, 10);
      cyc(0, 20, 0, 1, 15);     // low-battery blink
      cyc(0, 23, 0, 1, 10);     // inside hysteresis band
      cyc(0, 25, 0, 1, 10);     // leave low
      cyc(0, 100, 1, 1, 10);
      cyc(0, 200, 1, 1, 10);    // clamped full
      cyc(0, 200, 1, 0, 10);    // fan off
      cyc(0, 60, 1, 1, 300);    // ramp to duty 9
      cyc(0, 60, 0, 1, 3);
      cyc(0, 60, 1, 1, 100);    // re-entry restarts ramp
      cyc(1, 60, 1, 1, 3);      // reset mid-ramp
      cyc(0, 85, 1, 1, 80);     // breathing slot beyond last LED on 4-LED instance
      cyc(0, 13, 0, 1, 20);     // 8-LED threshold boundary
      for (int s = 0; s < 150; s++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       b = int'($urandom_range(0, 255));
            1:       b = int'($urandom_range(14, 30));
            2:       b = int'($urandom_range(70, 110));
            default: b = int'($urandom_range(0, 100));
         endcase
         c   = ($urandom_range(0, 1) == 1);
         f   = ($urandom_range(0, 9) != 0);
         r   = ($urandom_range(0, 29) == 0);
         len = int'($urandom_range(1, 40));
         cyc(r, b, c, f, len);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
